cnt_sched: RTL and testbench
============================

CNT_SCHED -- requirements
Module: cnt_sched

Interface
REQ-001 SHALL provide parameter NREQ, default 4, number of requesters sharing the counter.
REQ-002 SHALL provide parameter CW, default 8, counter and length width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port req_i  input  NREQ  per-requester timing request; held high until done_o or abort.
REQ-006 SHALL have port len_i  input  NREQ*CW  packed interval lengths; slice k = len_i[k*CW +: CW].
REQ-007 SHALL have port hold_i  input  1  pause; freezes the running count.
REQ-008 SHALL have port gnt_o  output  NREQ  one-hot grant; high for the owner throughout RUN.
REQ-009 SHALL have port done_o  output  NREQ  one-cycle completion pulse to the owner.
REQ-010 SHALL have port cnt_o  output  CW  current count of the shared counter.
REQ-011 SHALL have port busy_o  output  1  high in RUN and DONE.

Function
REQ-012 SHALL implement the states IDLE, RUN and DONE.
REQ-013 In IDLE with any req_i bit high, SHALL grant one requester k by round-robin: search starts at ptr, wraps modulo NREQ; SHALL latch len_i slice k into len_q; SHALL go to RUN.
REQ-014 After grant to k, SHALL set ptr to (k+1) mod NREQ.
REQ-015 In IDLE with req_i = 0, SHALL stay in IDLE with gnt_o = 0, done_o = 0, cnt_o = 0.
REQ-016 The first RUN cycle SHALL show gnt_o[k] = 1 and cnt_o = 0; the request is sampled in cycle T, so first RUN is T+1.
REQ-017 In RUN, each cycle with hold_i = 0 SHALL increment cnt_o by 1 modulo 2^CW; hold_i = 1 SHALL hold cnt_o.
REQ-018 In RUN, when cnt_o == len_q - 1 (CW-bit arithmetic) and hold_i = 0, the next state SHALL be DONE.
REQ-019 Consequence of REQ-018: len = L >= 1 SHALL give exactly L unheld RUN cycles, and len = 0 SHALL give 2^CW RUN cycles (count 0..2^CW-1, wrap).
REQ-020 In DONE, done_o[k] = 1 for exactly one cycle; gnt_o = 0; cnt_o = 0; next state IDLE.
REQ-021 DONE occurs at T+1+L with no hold, and the next grant is no earlier than T+L+3.
REQ-022 In RUN, if req_i[k] = 0, the next state SHALL be IDLE with cnt_o = 0 and no done_o pulse (abort).
REQ-023 Abort SHALL take priority over both hold_i and completion in the same cycle.
REQ-024 req_i bits of non-owners and changes to len_i SHALL have no effect during RUN or DONE.
REQ-025 A requester still requesting in the IDLE cycle after its DONE SHALL be re-eligible, subject to ptr.
REQ-026 gnt_o and done_o SHALL be at most one-hot at all times and never high together.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While reset = 0, SHALL asynchronously force state = IDLE, ptr = 0, len_q = 0, cnt_o = 0, gnt_o = 0, done_o = 0, busy_o = 0.
REQ-029 Reset asserted mid-RUN SHALL discard the job with no done_o; after release, arbitration restarts from requester 0.
REQ-030 Reset release SHALL be sampled on a rising clk edge; the first grant is possible in the cycle after release.

Verification
REQ-031 The bench SHALL cover: req_i = 0001, len0 = 5 -> gnt_o = 0001 for 5 cycles with cnt_o 0..4; done_o = 0001 in the next cycle; cnt_o = 0 after.
REQ-032 The bench SHALL cover: req_i = 1111 held, all lens = 2 -> grant order 0, 1, 2, 3, 0, with 4 cycles between successive grants.
REQ-033 The bench SHALL cover: len0 = 0 -> 256 RUN cycles; cnt_o wraps 255 after 254; done_o[0] follows cnt_o = 255.
REQ-034 The bench SHALL cover: len1 = 4, hold_i = 1 for 3 cycles when cnt_o = 2 -> cnt_o stays 2 for 3 cycles; done_o[1] is delayed by 3 cycles.
REQ-035 The bench SHALL cover: owner drops req when cnt_o = len-1 with hold_i = 1 -> IDLE next cycle; done_o stays 0; cnt_o = 0.
REQ-036 The bench SHALL cover: reset = 0 mid-RUN at cnt_o = 3 -> all outputs 0 immediately, without waiting for clk; after release with req_i = 0110, the first grant goes to requester 1.

Source files
------------

// File: rtl/cnt_sched.sv
// Shared interval counter time-shared among NREQ requesters by a round-robin arbiter.
// The owner's counter runs from 0 to len-1, with a pause input, then the owner gets a one-cycle done pulse.
module cnt_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*CW-1:0] len_i,
  input  logic              hold_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic [CW-1:0]     cnt_o,
  output logic              busy_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   len_q;
  logic [CW-1:0]   len_last;
  logic [CW-1:0]   len_arr [NREQ];
  logic            pick_vld;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   pick_next;

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign len_arr[g] = len_i[g*CW +: CW];
  end

  // A length of zero wraps to all ones here, which gives the full 2^CW-cycle interval.
  assign len_last = len_q - 1'b1;

  // Round-robin pick: the first requester found starting at ptr, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = 0; i < NREQ; i++) begin
      logic [IW-1:0] idx;
      idx = IW'((int'(ptr) + i) % NREQ);
      if (!pick_vld && req_i[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
    pick_next = (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      ptr    <= '0;
      owner  <= '0;
      len_q  <= '0;
      cnt_o  <= '0;
      gnt_o  <= '0;
      done_o <= '0;
      busy_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every branch reads the pre-edge state.
      done_o <= '0;
      case (state)
        S_IDLE: begin
          cnt_o <= '0;
          if (pick_vld) begin
            state  <= S_RUN;
            owner  <= pick;
            gnt_o  <= NREQ'(1) << pick;
            len_q  <= len_arr[pick];
            ptr    <= pick_next;
            busy_o <= 1'b1;
          end else begin
            gnt_o  <= '0;
            busy_o <= 1'b0;
          end
        end
        S_RUN: begin
          // Abort wins over both pause and completion.
          if (!req_i[owner]) begin
            state  <= S_IDLE;
            gnt_o  <= '0;
            cnt_o  <= '0;
            busy_o <= 1'b0;
          end else if (!hold_i) begin
            if (cnt_o == len_last) begin
              state  <= S_DONE;
              done_o <= gnt_o;
              gnt_o  <= '0;
              cnt_o  <= '0;
            end else begin
              cnt_o <= cnt_o + 1'b1;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          gnt_o  <= '0;
          cnt_o  <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_sched.sv
// Scoreboard bench for cnt_sched: a job-level reference model queues the expected outputs for each cycle,
// and a monitor pops one entry and compares it one time unit after every rising edge.
module tb_cnt_sched;

  localparam int NREQ = 4;
  localparam int CW   = 8;
  localparam int MOD  = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_i = '0;
  logic [NREQ*CW-1:0] len_i = '0;
  logic              hold_i = 1'b0;
  logic [NREQ-1:0]   gnt_o;
  logic [NREQ-1:0]   done_o;
  logic [CW-1:0]     cnt_o;
  logic              busy_o;

  cnt_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .clk    (clk),
    .reset  (rst_n),
    .req_i  (req_i),
    .len_i  (len_i),
    .hold_i (hold_i),
    .gnt_o  (gnt_o),
    .done_o (done_o),
    .cnt_o  (cnt_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic [CW-1:0]   cnt;
    logic            busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Job-level model: who owns the counter, how many unheld cycles it has left, and where the search starts.
  int m_owner = -1;
  int m_done  = 0;
  int m_cnt   = 0;
  int m_left  = 0;
  int m_ptr   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [NREQ*CW-1:0] pack(input int l0, input int l1, input int l2, input int l3);
    return {CW'(l3), CW'(l2), CW'(l1), CW'(l0)};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_done  = 0;
    m_cnt   = 0;
    m_left  = 0;
    m_ptr   = 0;
  endtask

  // Advance the model across one rising edge using the inputs now on the pins and queue the result.
  task automatic model_step();
    exp_t e;
    int   lv;
    e = '{gnt: '0, done: '0, cnt: '0, busy: 1'b0};
    if (m_done != 0) begin
      m_done = 0;
    end else if (m_owner < 0) begin
      if (req_i != '0) begin
        for (int i = 0; i < NREQ; i++) begin
          int k;
          k = (m_ptr + i) % NREQ;
          if (req_i[k]) begin
            m_owner = k;
            break;
          end
        end
        lv     = int'(len_i[m_owner*CW +: CW]);
        m_left = (lv == 0) ? MOD : lv;
        m_cnt  = 0;
        m_ptr  = (m_owner + 1) % NREQ;
        e.gnt  = NREQ'(1 << m_owner);
        e.busy = 1'b1;
      end
    end else begin
      if (!req_i[m_owner]) begin
        m_owner = -1;
        m_cnt   = 0;
      end else begin
        if (!hold_i) begin
          m_left--;
          if (m_left == 0) begin
            e.done  = NREQ'(1 << m_owner);
            e.busy  = 1'b1;
            m_owner = -1;
            m_done  = 1;
            m_cnt   = 0;
          end else begin
            m_cnt = (m_cnt + 1) % MOD;
          end
        end
        if (m_owner >= 0) begin
          e.gnt  = NREQ'(1 << m_owner);
          e.cnt  = CW'(m_cnt);
          e.busy = 1'b1;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] l, input logic h);
    @(negedge clk);
    req_i  = r;
    len_i  = l;
    hold_i = h;
    model_step();
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("gnt_o",  32'(gnt_o),  32'(mon_e.gnt));
      check("done_o", 32'(done_o), 32'(mon_e.done));
      check("cnt_o",  32'(cnt_o),  32'(mon_e.cnt));
      check("busy_o", 32'(busy_o), 32'(mon_e.busy));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0]    r;
    logic [NREQ*CW-1:0] l;
    int                 hc;
    int                 guard;

    #12;
    check("reset gnt_o",  32'(gnt_o),  32'h0);
    check("reset done_o", 32'(done_o), 32'h0);
    check("reset cnt_o",  32'(cnt_o),  32'h0);
    check("reset busy_o", 32'(busy_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesting, every length 2: grants 0,1,2,3,0 four cycles apart, then an abort.
    for (int i = 0; i < 17; i++) cycle(4'b1111, pack(2, 2, 2, 2), 1'b0);
    for (int i = 0; i < 2; i++)  cycle(4'b0000, pack(2, 2, 2, 2), 1'b0);

    // Single requester, length 5.
    for (int i = 0; i < 6; i++) cycle(4'b0001, pack(5, 0, 0, 0), 1'b0);
    for (int i = 0; i < 2; i++) cycle(4'b0000, pack(5, 0, 0, 0), 1'b0);

    // Length 0 runs the full 256 cycles and wraps.
    for (int i = 0; i < 258; i++) cycle(4'b0001, pack(0, 0, 0, 0), 1'b0);
    for (int i = 0; i < 2; i++)   cycle(4'b0000, pack(0, 0, 0, 0), 1'b0);

    // Requester 1, length 4, paused for 3 cycles while the count shows 2.
    hc = 0;
    for (int i = 0; i < 10; i++) begin
      logic h;
      h = (m_owner == 1 && m_cnt == 2 && hc < 3);
      if (h) hc++;
      cycle(4'b0010, pack(0, 4, 0, 0), h);
    end
    for (int i = 0; i < 2; i++) cycle(4'b0000, pack(0, 4, 0, 0), 1'b0);

    // Requester 2 drops its request at the last count while paused: abort, no done pulse.
    guard = 0;
    cycle(4'b0100, pack(0, 0, 3, 0), 1'b0);
    while (!(m_owner == 2 && m_cnt == 2) && guard < 10) begin
      cycle(4'b0100, pack(0, 0, 3, 0), 1'b0);
      guard++;
    end
    cycle(4'b0000, pack(0, 0, 3, 0), 1'b1);
    for (int i = 0; i < 2; i++) cycle(4'b0000, pack(0, 0, 3, 0), 1'b0);

    // Asynchronous reset while the count shows 3, then arbitration restarts from requester 0.
    cycle(4'b0001, pack(10, 0, 0, 0), 1'b0);
    guard = 0;
    while (m_cnt != 3 && guard < 10) begin
      cycle(4'b0001, pack(10, 0, 0, 0), 1'b0);
      guard++;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async gnt_o",  32'(gnt_o),  32'h0);
    check("async done_o", 32'(done_o), 32'h0);
    check("async cnt_o",  32'(cnt_o),  32'h0);
    check("async busy_o", 32'(busy_o), 32'h0);
    model_reset();
    req_i = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(4'b0110, pack(3, 3, 3, 3), 1'b0);
    for (int i = 0; i < 2; i++) cycle(4'b0000, pack(3, 3, 3, 3), 1'b0);

    // Random traffic: sticky requests that occasionally toggle, fresh lengths, random pauses.
    r = '0;
    l = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
        if ($urandom_range(0, 3) == 0)
          l[b*CW +: CW] = ($urandom_range(0, 19) == 0) ? CW'(0) : CW'($urandom_range(1, 6));
      end
      cycle(r, l, ($urandom_range(0, 4) == 0));
    end

    @(posedge clk);
    #2;
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
